// File: rtl/loa_pkg.sv
// Shared definitions for the lower-part-OR approximate accumulator family.
// Holds the FSM state encoding and the default sizing constants.
package loa_pkg;

    localparam int LOA_W       = 12;
    localparam int LOA_LOWER   = 4;
    localparam int LOA_N_TERMS = 9;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } loa_state_t;

endpackage

// File: rtl/loa_add.sv
// Lower-part-OR approximate adder: OR for the low LOWER bits, exact ripple above.
// The carry into the upper part is guessed from the top bit of the lower part.
module loa_add
    import loa_pkg::*;
#(
    parameter int W     = LOA_W,
    parameter int LOWER = LOA_LOWER
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-LOWER:0] w_carry;

    assign w_carry[0] = a[LOWER-1] & b[LOWER-1];

    genvar gi;
    generate
        for (gi = 0; gi < LOWER; gi++) begin : g_lower
            assign sum[gi] = a[gi] | b[gi];
        end

        // Upper part: one full adder per bit, carry rippling upward.
        for (gi = LOWER; gi < W; gi++) begin : g_upper
            assign sum[gi]               = a[gi] ^ b[gi] ^ w_carry[gi-LOWER];
            assign w_carry[gi-LOWER+1]   = (a[gi] & b[gi])
                                         | (a[gi] & w_carry[gi-LOWER])
                                         | (b[gi] & w_carry[gi-LOWER]);
        end
    endgenerate

    assign cout = w_carry[W-LOWER];

endmodule

// File: rtl/loa_accumulator.sv
// Windowed approximate accumulator: sums N_TERMS accepted terms with loa_add,
// saturates on overflow, then presents the result until downstream takes it.
module loa_accumulator
    import loa_pkg::*;
#(
    parameter int W       = LOA_W,
    parameter int LOWER   = LOA_LOWER,
    parameter int N_TERMS = LOA_N_TERMS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    localparam int              CNT_W    = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    loa_state_t      r_state;
    loa_state_t      w_state_next;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    w_acc_next;
    logic [W-1:0]    w_sum;
    logic            w_cout;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic            r_sat;
    logic            w_sat_next;
    logic            w_accept;
    logic            w_last;
    logic            w_drain;

    loa_add #(
        .W     (W),
        .LOWER (LOWER)
    ) u_add (
        .a    (r_acc),
        .b    (in_data),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_accept = in_valid && (r_state == ST_ACC);
    assign w_last   = (r_count == LAST_CNT);
    assign w_drain  = out_ready && (r_state == ST_OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_ACC;
                end
            end
            default: w_state_next = ST_ACC;
        endcase
    end

    // Once saturated, the window stays pinned at all-ones regardless of later terms.
    always_comb begin
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_sat_next   = r_sat;
        if (w_drain) begin
            w_acc_next   = '0;
            w_count_next = '0;
            w_sat_next   = 1'b0;
        end else if (w_accept) begin
            if (r_sat || w_cout) begin
                w_acc_next = '1;
                w_sat_next = 1'b1;
            end else begin
                w_acc_next = w_sum;
            end
            w_count_next = w_last ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_sat   <= w_sat_next;
        end
    end

    assign out_data = r_acc;
    assign out_sat  = r_sat;

endmodule

// File: tb/tb_loa_accumulator.sv
// Directed and randomized bench for loa_accumulator against an arithmetic
// model of the lower-part-OR rule with saturation.
module tb_loa_accumulator;

    localparam int W     = 12;
    localparam int LOWER = 4;
    localparam int N     = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sat;

    int checks = 0;
    int errors = 0;
    int m_acc  = 0;
    bit m_sat  = 1'b0;

    always #5 clk = ~clk;

    loa_accumulator #(
        .W       (W),
        .LOWER   (LOWER),
        .N_TERMS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: split into lower and upper fields and apply the rule arithmetically.
    task automatic model_accept(input int term);
        int lo_mask;
        int lo;
        int c;
        int hi;
        if (m_sat) return;
        lo_mask = (1 << LOWER) - 1;
        lo = (m_acc & lo_mask) | (term & lo_mask);
        c  = ((m_acc >> (LOWER - 1)) & 1) * ((term >> (LOWER - 1)) & 1);
        hi = (m_acc >> LOWER) + (term >> LOWER) + c;
        if (hi >= (1 << (W - LOWER))) begin
            m_acc = (1 << W) - 1;
            m_sat = 1'b1;
        end else begin
            m_acc = (hi << LOWER) + lo;
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_sat = 1'b0;
    endtask

    task automatic accept_term(input logic [W-1:0] t, input string tag);
        in_valid = 1'b1;
        in_data  = t;
        @(negedge clk);
        check($sformatf("%s in_ready", tag), in_ready, 1);
        check($sformatf("%s out_valid_low", tag), out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_accept(t);
        check($sformatf("%s acc", tag), out_data, m_acc);
        check($sformatf("%s sat", tag), out_sat, m_sat);
        $display("accept %-10s term=0x%03h acc=0x%03h sat=%0d", tag, t, out_data, out_sat);
    endtask

    task automatic bubbles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one step after the last accept: result visible, then stall and drain.
    task automatic finish_window(input string tag, input int stall);
        out_ready = (stall == 0);
        in_valid  = (stall > 0);
        for (int k = 0; k < stall; k++) begin
            in_data = W'($urandom);
            @(negedge clk);
            check($sformatf("%s stall out_valid", tag), out_valid, 1);
            check($sformatf("%s stall in_ready", tag), in_ready, 0);
            check($sformatf("%s stall data", tag), out_data, m_acc);
            check($sformatf("%s stall sat", tag), out_sat, m_sat);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("%s out_valid", tag), out_valid, 1);
        check($sformatf("%s out_data", tag), out_data, m_acc);
        check($sformatf("%s out_sat", tag), out_sat, m_sat);
        $display("window %-10s out=0x%03h sat=%0d stall=%0d", tag, out_data, out_sat, stall);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        model_clear();
        check($sformatf("%s drained valid", tag), out_valid, 0);
        check($sformatf("%s drained ready", tag), in_ready, 1);
        check($sformatf("%s cleared data", tag), out_data, 0);
        check($sformatf("%s cleared sat", tag), out_sat, 0);
    endtask

    task automatic directed(input logic [W-1:0] val, input logic [W-1:0] exp_data,
                            input logic exp_sat, input int stall, input string tag);
        out_ready = (stall == 0);
        for (int i = 0; i < N; i++) accept_term(val, tag);
        check($sformatf("%s latency valid", tag), out_valid, 1);
        check($sformatf("%s spec data", tag), out_data, exp_data);
        check($sformatf("%s spec sat", tag), out_sat, exp_sat);
        finish_window(tag, stall);
    endtask

    task automatic random_window(input string tag);
        logic [W-1:0] t;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            bubbles($urandom_range(0, 2));
            t = W'($urandom_range(0, (1 << W) - 1) >> $urandom_range(2, 5));
            accept_term(t, tag);
        end
        finish_window(tag, $urandom_range(0, 3));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sat", out_sat, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        directed(12'h010, 12'h090, 1'b0, 0, "d010");
        directed(12'h008, 12'h088, 1'b0, 0, "d008");
        directed(12'h001, 12'h001, 1'b0, 0, "d001");
        directed(12'h200, 12'hFFF, 1'b1, 0, "d200");
        directed(12'h010, 12'h090, 1'b0, 5, "stall");
        directed(12'h008, 12'h088, 1'b0, 0, "afterstl");

        // Partial window discarded by an asynchronous reset pulse.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) accept_term(12'h033, "partial");
        #2;
        rst = 1'b1;
        #1;
        check("async rst data", out_data, 0);
        check("async rst sat", out_sat, 0);
        check("async rst valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("held rst data", out_data, 0);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        directed(12'h010, 12'h090, 1'b0, 0, "postrst");

        for (int r = 0; r < 8; r++) random_window($sformatf("rand%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
